// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state, request and response records.
package dmem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        is_wr;
    logic        err;
  } dmem_rsp_t;

  // Word reads, halfword writes and word writes must sit on their natural boundary.
  function automatic logic is_misaligned(input dmem_req_t req);
    logic bad;
    bad = 1'b0;
    if (req.be == 4'b0000)
      bad = (req.addr[1:0] != 2'b00);
    else if (req.be == 4'b0011 || req.be == 4'b1100)
      bad = req.addr[0];
    else if (req.be == 4'b1111)
      bad = (req.addr[1:0] != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port DEPTH x 32 data array with per-byte write enable and registered read port.
module dmem_bram #(
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  generate
    if (INIT_ZERO != 0) begin : g_clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (en) begin
          for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end else begin : g_noclear
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  endgenerate

  // Read register only loads on reads, so it holds the response word until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (en && we == 4'b0000)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed LATENCY, valid/ready on both sides.
// Optional macro DMEM_MISALIGN_EN enables misaligned-access detection and rsp_err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_is_wr,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t state;
  logic [3:0]  cnt;
  dmem_req_t   req_q;
  dmem_req_t   req_in;
  dmem_req_t   cmt_req;
  dmem_rsp_t   rsp;
  logic        commit;
  logic        cmt_err;
  logic        bram_en;
  logic [31:0] bram_rdata;
  logic        wr_q;
  logic        err_q;
  logic        unused_addr_bits;

  assign req_in = '{addr: req_addr, wdata: req_wdata, be: req_be};

  // With LATENCY==1 the access executes on the accept edge straight from the inputs.
  always_comb begin
    commit  = 1'b0;
    cmt_req = req_q;
    if (LATENCY == 1) begin
      commit  = (state == IDLE) && req_valid && req_ready;
      cmt_req = req_in;
    end else begin
      commit  = (state == WAIT) && (cnt == 4'd1);
    end
`ifdef DMEM_MISALIGN_EN
    cmt_err = is_misaligned(cmt_req);
`else
    cmt_err = 1'b0;
`endif
  end

  assign bram_en          = commit && !cmt_err;
  assign unused_addr_bits = ^{cmt_req.addr[31:AW+2], cmt_req.addr[1:0]};

  dmem_bram #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_bram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bram_en),
    .addr  (cmt_req.addr[AW+1:2]),
    .we    (cmt_req.be),
    .wdata (cmt_req.wdata),
    .rdata (bram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            req_q     <= req_in;
            cnt       <= 4'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Commit edge: the array access happens now and the response fields latch.
      if (commit) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        wr_q      <= |cmt_req.be;
        err_q     <= cmt_err;
      end
    end
  end

  assign rsp.rdata = (wr_q || err_q) ? '0 : bram_rdata;
  assign rsp.is_wr = wr_q;
  assign rsp.err   = err_q;

  assign rsp_rdata = rsp.rdata;
  assign rsp_is_wr = rsp.is_wr;
  assign rsp_err   = rsp.err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder; the far end of the MEM-stage load/store request.
- The MEM stage drives the request from bus_stage2 fields: ex_out is the byte address, rf_rdata2 is the store data, and dmem_wr_en is the byte-lane write mask.
- The block accepts one request at a time with a valid/ready handshake and applies a fixed programmable latency.
- It returns a response with valid/ready handshake, carrying read data or a write acknowledge, back toward the WB stage.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.
- INIT_ZERO, 1, when 1 the memory array is cleared by reset; when 0 the array contents are undefined after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address (ex_out).
- req_wdata  in  32  store data (rf_rdata2).
- req_be  in  4  byte write enable (dmem_wr_en); 4'b0000 means read.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  read word; 0 for writes.
- rsp_is_wr  out  1  response belongs to a write.
- rsp_err  out  1  error flag; driven 0 unless DMEM_MISALIGN_EN is defined.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state goes to IDLE; req_ready=0 while rst_n is low; rsp_valid=0, rsp_rdata=0, rsp_is_wr=0, rsp_err=0.
  - Latency counter cleared to 0; captured request registers cleared.
  - If INIT_ZERO=1, all words are cleared by reset.
- Reset mid-operation: any in-flight request or pending response is dropped; a pending write that has not reached commit is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr, wdata and be; set cnt=LATENCY-1.
  - Go to WAIT, or directly to RESP if LATENCY==1.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==1, the access executes on that clock edge and the state goes to RESP.
- Access execution (the commit edge):
  - Word index = addr[$clog2(DEPTH)+1:2]; upper address bits are ignored, so the address wraps modulo DEPTH*4.
  - Write (be!=0): each byte lane i with be[i]=1 is updated from wdata[8i+7:8i]; other lanes are unchanged. rsp_rdata=0, rsp_is_wr=1.
  - Read (be==0): rsp_rdata=mem[index], rsp_is_wr=0.
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_is_wr and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE with rsp_valid=0 on the next cycle.
  - The next request is accepted no earlier than the cycle after the response handshake, so at most one request is in flight.
- Timing: a request accepted at edge T produces rsp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- req_valid while req_ready=0 is ignored; the requester holds its request (standard valid/ready).
- Inputs req_* are sampled only on the accept edge; later changes have no effect on the in-flight request.
- The array has a single read/write port: reads and writes never collide because only one request is in flight.

Optional Feature:
- Macro name: DMEM_MISALIGN_EN.
- Defined, misaligned access: a misaligned access is one of the following.
  - A read with addr[1:0]!=0.
  - A write with be==4'b0011 or 4'b1100 and addr[0]!=0.
  - A write with be==4'b1111 and addr[1:0]!=0.
- Defined, effect: on a misaligned access the write is suppressed, a read returns 0, and rsp_err=1. Latency and handshake are unchanged.
- Not defined: rsp_err is tied to 0 and addr[1:0] is ignored.

Decomposition:
- Add to the shared pipeline package:
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP}.
  - packed struct dmem_req_t {addr[31:0], wdata[31:0], be[3:0]}.
  - packed struct dmem_rsp_t {rdata[31:0], is_wr, err}.
- One sub-module: dmem_bram.
  - Single-port DEPTH x 32 array with per-byte write enable and synchronous read.
  - Reset clear under INIT_ZERO.
  - The FSM and counter stay in dmem_responder.

Test Plan:
- Write then read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read addr=0x10 -> write response has rsp_is_wr=1, rsp_rdata=0; read response has rsp_rdata=0xDEADBEEF; each rsp_valid rises exactly 2 cycles after its accept.
- Byte-lane write: write 0x11223344 to addr 0x20, then write be=4'b0100, wdata=0x00AA0000 -> read of 0x20 returns 0x11AA3344.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; after rsp_ready=1, req_ready=1 on the next cycle.
- Address wrap, DEPTH=1024: write 0xCAFEF00D to addr 0x1004 -> a read of addr 0x0004 returns 0xCAFEF00D.
- Reset mid-operation: assert rst_n=0 in the WAIT state of a write to 0x30 -> rsp_valid=0 immediately; after reset, a read of 0x30 returns 0 (INIT_ZERO=1).
- DMEM_MISALIGN_EN defined: read addr=0x13 -> rsp_err=1, rsp_rdata=0; a be=4'hF write to 0x42 -> rsp_err=1 and a following read of 0x40 is unchanged.
